// File: rtl/sim_kbd_driver_pkg.sv
// Shared definitions for the keyboard stimulus driver: state encodings,
// status counter width and a saturating increment helper.
package sim_kbd_driver_pkg;

  localparam int CNT_W = 16;

  localparam logic [1:0] KBD_ST_IDLE   = 2'd0;
  localparam logic [1:0] KBD_ST_ASSERT = 2'd1;
  localparam logic [1:0] KBD_ST_GAP    = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sim_kbd_driver_if.sv
// Keyboard interrupt handshake between the stimulus driver and the system.
interface sim_kbd_driver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  kbd_int;
  logic [DATA_WIDTH-1:0] kbd_data;
  logic                  kbd_int_ack;

  modport master (output kbd_int, output kbd_data, input kbd_int_ack);
  modport slave  (input kbd_int, input kbd_data, output kbd_int_ack);
endinterface

// File: rtl/sim_kbd_driver_fifo.sv
// Synchronous code queue. A push into a full queue is accepted when a pop
// happens on the same edge, leaving the count unchanged.
module sim_byte_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // pointer and count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array; contents are don't-care while the queue is empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sim_kbd_driver.sv
// Scripted keyboard interrupt driver: presents queued codes one at a time,
// waits for a synchronised ack, retries on timeout and keeps status counters.
//
//  state  | meaning
//  IDLE   | kbd_int low, waiting for enable and a queued code
//  ASSERT | kbd_int high with head code on kbd_data, waiting for ack or timeout
//  GAP    | kbd_int low for GAP_CYCLES before the next code may be raised
module sim_kbd_driver
  import sim_kbd_driver_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int GAP_CYCLES  = 64,
  parameter int ACK_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  sim_kbd_driver_if.master      kbd,
  output logic                  busy,
  output logic [CNT_W-1:0]      sent_cnt,
  output logic [CNT_W-1:0]      timeout_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      spurious_cnt
);
  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_s, ack_s_d_q, ack_rise;
  logic [1:0]             state_q, state_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   int_q, int_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]       sent_q, sent_d, tmo_q, tmo_d, drop_q, drop_d, spur_q, spur_d;
  logic                   pop, push, full, empty;
  logic [DATA_WIDTH-1:0]  head;

  sim_byte_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (load_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign load_ready   = ~full | pop;
  assign push         = load_valid & load_ready;
  assign busy         = (state_q != KBD_ST_IDLE) | ~empty;
  assign ack_s        = sync_q[SYNC_STAGES-1];
  assign ack_rise     = ack_s & ~ack_s_d_q;
  assign kbd.kbd_int  = int_q;
  assign kbd.kbd_data = data_q;
  assign sent_cnt     = sent_q;
  assign timeout_cnt  = tmo_q;
  assign drop_cnt     = drop_q;
  assign spurious_cnt = spur_q;

  // shift the asynchronous ack into the clk domain
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = kbd.kbd_int_ack;
  end

  // handshake FSM, timer, retry count and status counters
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    int_d   = int_q;
    data_d  = data_q;
    sent_d  = sent_q;
    tmo_d   = tmo_q;
    drop_d  = drop_q;
    spur_d  = spur_q;
    pop     = 1'b0;

    if (ack_rise && (state_q != KBD_ST_ASSERT)) spur_d = sat_inc(spur_q);

    case (state_q)
      KBD_ST_IDLE: begin
        int_d = 1'b0;
        if (enable && !empty) begin
          state_d = KBD_ST_ASSERT;
          int_d   = 1'b1;
          data_d  = head;
          tmr_d   = '0;
        end
      end
      KBD_ST_ASSERT: begin
        // ack takes priority over a timeout landing on the same cycle
        if (ack_rise) begin
          pop     = 1'b1;
          sent_d  = sat_inc(sent_q);
          retry_d = '0;
          int_d   = 1'b0;
          tmr_d   = '0;
          state_d = KBD_ST_GAP;
        end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
          tmo_d   = sat_inc(tmo_q);
          int_d   = 1'b0;
          tmr_d   = '0;
          state_d = KBD_ST_GAP;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
          end else begin
            pop     = 1'b1;
            drop_d  = sat_inc(drop_q);
            retry_d = '0;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      KBD_ST_GAP: begin
        int_d = 1'b0;
        if (tmr_q == TW'(GAP_CYCLES - 1)) begin
          tmr_d = '0;
          if (enable && !empty) begin
            state_d = KBD_ST_ASSERT;
            int_d   = 1'b1;
            data_d  = head;
          end else begin
            state_d = KBD_ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = KBD_ST_IDLE;
        int_d   = 1'b0;
        tmr_d   = '0;
      end
    endcase
  end

  // all driver state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      ack_s_d_q <= 1'b0;
      state_q   <= KBD_ST_IDLE;
      tmr_q     <= '0;
      retry_q   <= '0;
      int_q     <= 1'b0;
      data_q    <= '0;
      sent_q    <= '0;
      tmo_q     <= '0;
      drop_q    <= '0;
      spur_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      ack_s_d_q <= ack_s;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      retry_q   <= retry_d;
      int_q     <= int_d;
      data_q    <= data_d;
      sent_q    <= sent_d;
      tmo_q     <= tmo_d;
      drop_q    <= drop_d;
      spur_q    <= spur_d;
    end
  end

endmodule

// File: tb/tb_sim_kbd_driver.sv
// Directed bench for sim_kbd_driver with default parameters.
module tb_sim_kbd_driver;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        busy;
  logic [15:0] sent_cnt, timeout_cnt, drop_cnt, spurious_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  sim_kbd_driver_if #(.DATA_WIDTH(8)) kif ();

  sim_kbd_driver dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .kbd          (kif),
    .busy         (busy),
    .sent_cnt     (sent_cnt),
    .timeout_cnt  (timeout_cnt),
    .drop_cnt     (drop_cnt),
    .spurious_cnt (spurious_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0; kif.kbd_int_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] c);
    load_valid = 1'b1; load_data = c;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // counts low negedges (including the current one) until kbd_int is seen high
  task automatic wait_high(input int budget, output int lows, output bit ok);
    lows = 0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (kif.kbd_int === 1'b1) begin ok = 1'b1; break; end
      lows++;
      @(negedge clk);
    end
  endtask

  // system side: ack 'delay' negedges after kbd_int is seen high, release once it drops
  task automatic serve(input int delay, output logic [7:0] code, output bit stable,
                       output int lows, output int highs, output bit ok);
    bit okh;
    ok = 1'b0; stable = 1'b1; highs = 0; code = '0;
    wait_high(200, lows, okh);
    if (!okh) return;
    code  = kif.kbd_data;
    highs = 1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (kif.kbd_int === 1'b1) begin
        highs++;
        if (kif.kbd_data !== code) stable = 1'b0;
      end
    end
    kif.kbd_int_ack = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (kif.kbd_int !== 1'b1) begin ok = 1'b1; break; end
      highs++;
      if (kif.kbd_data !== code) stable = 1'b0;
    end
    kif.kbd_int_ack = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++; if (kif.kbd_int !== 1'b0) begin tests_failed++; $display("FAIL rst_int: got %b want 0", kif.kbd_int); end
    tests_run++; if (kif.kbd_data !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got %h want 00", kif.kbd_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests_run++; if (load_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b want 1", load_ready); end
    tests_run++; if ({sent_cnt, timeout_cnt, drop_cnt, spurious_cnt} !== 64'd0) begin
      tests_failed++; $display("FAIL rst_cnts: got %h %h %h %h want all 0", sent_cnt, timeout_cnt, drop_cnt, spurious_cnt);
    end
  endtask

  task automatic test_single();
    logic [7:0] code; bit stable, ok; int lows, highs;
    do_reset();
    enable = 1'b1;
    push(8'h61);
    serve(3, code, stable, lows, highs, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL t1_handshake: got timeout want done"); end
    tests_run++; if (code !== 8'h61 || !stable) begin tests_failed++; $display("FAIL t1_data: got %h stable=%0d want 61", code, stable); end
    // 1 rise negedge + 3 delay negedges + SYNC_STAGES sync edges before the drop
    tests_run++; if (highs !== 6) begin tests_failed++; $display("FAIL t1_ack_latency: got %0d want 6", highs); end
    tests_run++; if (sent_cnt !== 16'd1) begin tests_failed++; $display("FAIL t1_sent: got %0d want 1", sent_cnt); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL t1_busy_gap: got %b want 1", busy); end
    wait_idle(100, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL t1_busy_idle: got busy=1 want 0"); end
  endtask

  task automatic test_sequence();
    logic [7:0] code; bit stable, ok; int lows, highs;
    logic [7:0] exp;
    do_reset();
    enable = 1'b1;
    push(8'h61); push(8'h62); push(8'h63);
    for (int i = 0; i < 3; i++) begin
      exp = 8'h61 + 8'(i);
      serve(3, code, stable, lows, highs, ok);
      tests_run++; if (!ok || code !== exp || !stable) begin
        tests_failed++; $display("FAIL t2_code%0d: got %h ok=%0d want %h", i, code, ok, exp);
      end
      if (i > 0) begin
        tests_run++; if (lows !== 64) begin tests_failed++; $display("FAIL t2_gap%0d: got %0d want 64", i, lows); end
      end
    end
    tests_run++; if (sent_cnt !== 16'd3) begin tests_failed++; $display("FAIL t2_sent: got %0d want 3", sent_cnt); end
  endtask

  task automatic test_timeout();
    bit ok; int lows, highs;
    do_reset();
    enable = 1'b1;
    push(8'h41);
    for (int r = 0; r < 3; r++) begin
      wait_high(200, lows, ok);
      tests_run++; if (!ok || kif.kbd_data !== 8'h41) begin
        tests_failed++; $display("FAIL t3_assert%0d: got ok=%0d data=%h want 41", r, ok, kif.kbd_data);
      end
      if (r > 0) begin
        tests_run++; if (lows !== 64) begin tests_failed++; $display("FAIL t3_gap%0d: got %0d want 64", r, lows); end
      end
      highs = 0;
      for (int i = 0; i < 2000; i++) begin
        if (kif.kbd_int !== 1'b1) break;
        highs++;
        @(negedge clk);
      end
      tests_run++; if (highs !== 1024) begin tests_failed++; $display("FAIL t3_high%0d: got %0d want 1024", r, highs); end
    end
    wait_idle(100, ok);
    tests_run++; if (!ok || kif.kbd_int !== 1'b0) begin tests_failed++; $display("FAIL t3_idle: got busy=%b int=%b want 0 0", busy, kif.kbd_int); end
    tests_run++; if (timeout_cnt !== 16'd3) begin tests_failed++; $display("FAIL t3_timeouts: got %0d want 3", timeout_cnt); end
    tests_run++; if (drop_cnt !== 16'd1) begin tests_failed++; $display("FAIL t3_drops: got %0d want 1", drop_cnt); end
    tests_run++; if (sent_cnt !== 16'd0) begin tests_failed++; $display("FAIL t3_sent: got %0d want 0", sent_cnt); end
  endtask

  task automatic test_full();
    logic [7:0] code, exp; bit stable, ok; int lows, highs;
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    tests_run++; if (load_ready !== 1'b0) begin tests_failed++; $display("FAIL t4_full_ready: got %b want 0", load_ready); end
    tests_run++; if (kif.kbd_int !== 1'b0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL t4_disabled: got int=%b busy=%b want 0 1", kif.kbd_int, busy);
    end
    load_valid = 1'b1; load_data = 8'h20;
    enable = 1'b1;
    serve(3, code, stable, lows, highs, ok);
    load_valid = 1'b0;
    tests_run++; if (!ok || code !== 8'h10) begin tests_failed++; $display("FAIL t4_first: got %h ok=%0d want 10", code, ok); end
    tests_run++; if (load_ready !== 1'b0) begin tests_failed++; $display("FAIL t4_refull: got %b want 0", load_ready); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'h20 : 8'h11 + 8'(i);
      serve(3, code, stable, lows, highs, ok);
      tests_run++; if (!ok || code !== exp) begin tests_failed++; $display("FAIL t4_code%0d: got %h ok=%0d want %h", i, code, ok, exp); end
    end
    tests_run++; if (sent_cnt !== 16'd17) begin tests_failed++; $display("FAIL t4_sent: got %0d want 17", sent_cnt); end
  endtask

  task automatic test_spurious_and_race();
    logic [7:0] code; bit stable, ok; int lows, highs;
    do_reset();
    enable = 1'b1;
    kif.kbd_int_ack = 1'b1;
    repeat (2) @(negedge clk);
    kif.kbd_int_ack = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++; if (spurious_cnt !== 16'd1) begin tests_failed++; $display("FAIL t5_spurious: got %0d want 1", spurious_cnt); end
    tests_run++; if (kif.kbd_int !== 1'b0 || sent_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL t5_no_effect: got int=%b sent=%0d want 0 0", kif.kbd_int, sent_cnt);
    end
    // ack driven 1021 negedges after the rise reaches the FSM on the tmr==1023 edge
    push(8'h55);
    serve(1021, code, stable, lows, highs, ok);
    tests_run++; if (!ok || highs !== 1024 || code !== 8'h55) begin
      tests_failed++; $display("FAIL t5_race_high: got ok=%0d highs=%0d code=%h want 1 1024 55", ok, highs, code);
    end
    repeat (80) @(negedge clk);
    tests_run++; if (sent_cnt !== 16'd1 || timeout_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL t5_race_cnts: got sent=%0d tmo=%0d want 1 0", sent_cnt, timeout_cnt);
    end
    tests_run++; if (kif.kbd_int !== 1'b0 || spurious_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL t5_race_after: got int=%b spur=%0d want 0 1", kif.kbd_int, spurious_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] code; bit stable, ok; int lows, highs;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
    serve(3, code, stable, lows, highs, ok);
    wait_high(200, lows, ok);
    tests_run++; if (!ok || sent_cnt !== 16'd1) begin tests_failed++; $display("FAIL t6_setup: got ok=%0d sent=%0d want 1 1", ok, sent_cnt); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (kif.kbd_int !== 1'b0 || kif.kbd_data !== 8'h00) begin
      tests_failed++; $display("FAIL t6_int: got int=%b data=%h want 0 00", kif.kbd_int, kif.kbd_data);
    end
    tests_run++; if (sent_cnt !== 16'd0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      tests_failed++; $display("FAIL t6_state: got sent=%0d busy=%b ready=%b want 0 0 1", sent_cnt, busy, load_ready);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++; if (kif.kbd_int !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL t6_empty: got int=%b busy=%b want 0 0", kif.kbd_int, busy);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0; kif.kbd_int_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_sequence();
    test_timeout();
    test_full();
    test_spurious_and_race();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
